// File: rtl/csa_seq_mult.sv
// ----------------------------------------------------------------------------
// csa_seq_mult
//   Iterative shift-and-add multiplier built around an external 2*WIDTH-bit
//   carry-save adder. Each ACCUM step presents the running redundant pair
//   (sum_q, cout_q<<1) plus one partial product to the CSA and registers the
//   returned sum/carry vectors. RESOLVE collapses the pair with a single
//   carry-propagate add. Sits between the operand registers and the ALU
//   result mux.
//
//   Optional feature: define CSA_MULT_SIGNED_EN for two's complement
//   operands (sign-extended partial products, subtract on the last step).
//   Without it, operands are unsigned and cin_bit is tied low.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   start_i      request, only sampled in IDLE
//   a_i, b_i     multiplicand / multiplier, captured on accepted start
//   busy_o       high in ACCUM and RESOLVE
//   done_o       one-cycle pulse, product_o valid from this cycle on
//   product_o    2*WIDTH-bit result, held until the next accepted start
//   csa_a_o      CSA input a (sum_q)
//   csa_b_o      CSA input b ({cout_q[2W-2:0], cin_bit})
//   csa_c_o      CSA input c (partial product)
//   csa_cout_i   CSA carry vector
//   csa_sum_i    CSA sum vector
// ----------------------------------------------------------------------------
module csa_seq_mult #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [2*WIDTH-1:0]   csa_a_o,
    output logic [2*WIDTH-1:0]   csa_b_o,
    output logic [2*WIDTH-1:0]   csa_c_o,
    input  logic [2*WIDTH-1:0]   csa_cout_i,
    input  logic [2*WIDTH-1:0]   csa_sum_i
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [PW-1:0]      product_q;
    logic [PW-1:0]      sum_q;
    logic [PW-1:0]      cout_q;
    logic [CNT_W-1:0]   step_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [PW-1:0]      a_ext;
    logic [WIDTH-1:0]   b_shift;
    logic               cin_bit;
    logic [PW-1:0]      product_d;

`ifdef CSA_MULT_SIGNED_EN
    assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
`else
    assign a_ext = {{WIDTH{1'b0}}, a_q};
`endif

    // Multiplier bit for the current step lands in bit 0.
    assign b_shift = b_q >> step_q;

    // Carry vector is weighted by 2; its MSB falls off (mod 2**PW).
    assign product_d = sum_q + {cout_q[PW-2:0], 1'b0};

    always_comb begin
        csa_a_o = '0;
        csa_b_o = '0;
        csa_c_o = '0;
        cin_bit = 1'b0;
        if (state_q == ACCUM) begin
            csa_a_o = sum_q;
`ifdef CSA_MULT_SIGNED_EN
            // MSB of a two's complement multiplier has negative weight:
            // add the inverted partial product and a carry-in of one.
            if (step_q == LAST_STEP && b_q[WIDTH-1]) begin
                csa_c_o = ~(a_ext << step_q);
                cin_bit = 1'b1;
            end else if (b_shift[0]) begin
                csa_c_o = a_ext << step_q;
            end
`else
            if (b_shift[0]) begin
                csa_c_o = a_ext << step_q;
            end
`endif
            // Bit 0 of the shifted carry vector is always free for cin.
            csa_b_o = {cout_q[PW-2:0], cin_bit};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            sum_q     <= '0;
            cout_q    <= '0;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        sum_q   <= '0;
                        cout_q  <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum_q  <= csa_sum_i;
                    cout_q <= csa_cout_i;
                    step_q <= step_q + CNT_W'(1);
                    if (step_q == LAST_STEP) begin
                        state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    product_q <= product_d;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_csa_seq_mult.sv
// ----------------------------------------------------------------------------
// tb_csa_seq_mult
//   Directed-vector bench for csa_seq_mult. A behavioural 3:2 carry-save
//   adder closes the loop on the csa_* ports. Expected products are
//   hand-computed constants.
// ----------------------------------------------------------------------------
module tb_csa_seq_mult;

    localparam int W  = 10;
    localparam int PW = 20;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          busy_o;
    logic          done_o;
    logic [PW-1:0] product_o;
    logic [PW-1:0] csa_a_o;
    logic [PW-1:0] csa_b_o;
    logic [PW-1:0] csa_c_o;
    logic [PW-1:0] csa_cout_i;
    logic [PW-1:0] csa_sum_i;

    int n_vec = 0;
    int n_bad = 0;

    csa_seq_mult #(.WIDTH(W), .CNT_W(4)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .product_o  (product_o),
        .csa_a_o    (csa_a_o),
        .csa_b_o    (csa_b_o),
        .csa_c_o    (csa_c_o),
        .csa_cout_i (csa_cout_i),
        .csa_sum_i  (csa_sum_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference 3:2 compressor.
    always_comb begin
        csa_sum_i  = csa_a_o ^ csa_b_o ^ csa_c_o;
        csa_cout_i = (csa_a_o & csa_b_o) | (csa_a_o & csa_c_o) | (csa_b_o & csa_c_o);
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Accepts an operation on the next edge, then runs until done (bounded).
    // Returns the done cycle, the number of busy cycles before it and
    // csa_c on cycles 1..3. poke_cyc>0 pulses a spurious start on that cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke_cyc,
                          output int done_cyc, output int busy_cnt,
                          output logic [PW-1:0] c1, output logic [PW-1:0] c2,
                          output logic [PW-1:0] c3);
        int cyc;
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        c1 = '0;
        c2 = '0;
        c3 = '0;
        while (!done_o && cyc < 40) begin
            if (busy_o) busy_cnt++;
            if (cyc == 1) c1 = csa_c_o;
            if (cyc == 2) c2 = csa_c_o;
            if (cyc == 3) c3 = csa_c_o;
            if (cyc == poke_cyc) begin
                a_i = 10'd9;
                b_i = 10'd9;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
        done_cyc = cyc;
    endtask

    initial begin
        int dc, bc, ndone;
        logic [PW-1:0] c1, c2, c3;

        reset_i = 1'b1;
        start_i = 1'b0;
        a_i = '0;
        b_i = '0;
        tick();
        tick();
        check_vec("rst_busy", 32'(busy_o), 32'd0);
        check_vec("rst_done", 32'(done_o), 32'd0);
        check_vec("rst_product", 32'(product_o), 32'd0);
        check_vec("rst_csa_a", 32'(csa_a_o), 32'd0);
        check_vec("rst_csa_b", 32'(csa_b_o), 32'd0);
        check_vec("rst_csa_c", 32'(csa_c_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // 3 * 5: latency, busy window, partial products for bits 0..2.
        run_op(10'd3, 10'd5, 0, dc, bc, c1, c2, c3);
        check_vec("t1_done_cyc", 32'(dc), 32'd12);
        check_vec("t1_busy_cnt", 32'(bc), 32'd11);
        check_vec("t1_busy_at_done", 32'(busy_o), 32'd0);
        check_vec("t1_product", 32'(product_o), 32'd15);
        check_vec("t1_pp0", 32'(c1), 32'd3);
        check_vec("t1_pp1", 32'(c2), 32'd0);
        check_vec("t1_pp2", 32'(c3), 32'd12);
        tick();
        check_vec("t1_done_pulse", 32'(done_o), 32'd0);
        check_vec("t1_product_held", 32'(product_o), 32'd15);
        check_vec("t1_csa_c_idle", 32'(csa_c_o), 32'd0);
        tick();

        // Max operands: long carry chain.
        run_op(10'h3FF, 10'h3FF, 0, dc, bc, c1, c2, c3);
        check_vec("t2_done_cyc", 32'(dc), 32'd12);
`ifdef CSA_MULT_SIGNED_EN
        check_vec("t2_product", 32'(product_o), 32'h00001);
`else
        check_vec("t2_product", 32'(product_o), 32'hFF801);
`endif
        tick();

        // Alternating bit patterns.
        run_op(10'h2AA, 10'h155, 0, dc, bc, c1, c2, c3);
`ifdef CSA_MULT_SIGNED_EN
        check_vec("t2b_product", 32'(product_o), 32'hE3872);
`else
        check_vec("t2b_product", 32'(product_o), 32'h38C72);
`endif
        tick();

        // Spurious start mid-operation must be ignored.
        run_op(10'd3, 10'd5, 4, dc, bc, c1, c2, c3);
        check_vec("t3_done_cyc", 32'(dc), 32'd12);
        check_vec("t3_product", 32'(product_o), 32'd15);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_o) ndone++;
        end
        check_vec("t3_extra_done", 32'(ndone), 32'd0);
        check_vec("t3_idle_busy", 32'(busy_o), 32'd0);

        // Synchronous reset in the middle of ACCUM.
        a_i = 10'd4;
        b_i = 10'd4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 6; i++) tick();
        check_vec("t4_busy_before", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_vec("t4_busy", 32'(busy_o), 32'd0);
        check_vec("t4_product", 32'(product_o), 32'd0);
        check_vec("t4_done", 32'(done_o), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_o || busy_o) ndone++;
        end
        check_vec("t4_no_activity", 32'(ndone), 32'd0);

        // Back-to-back: start held through the done cycle is only taken after it.
        run_op(10'd6, 10'd7, 0, dc, bc, c1, c2, c3);
        check_vec("t5a_product", 32'(product_o), 32'd42);
        a_i = 10'd7;
        b_i = 10'd0;
        start_i = 1'b1;
        tick();
        check_vec("t5_ign_on_done", 32'(busy_o), 32'd0);
        run_op(10'd7, 10'd0, 0, dc, bc, c1, c2, c3);
        check_vec("t5_done_cyc", 32'(dc), 32'd12);
        check_vec("t5_product", 32'(product_o), 32'd0);
        tick();

`ifdef CSA_MULT_SIGNED_EN
        run_op(10'h3FD, 10'd5, 0, dc, bc, c1, c2, c3);
        check_vec("t6_neg3x5", 32'(product_o), 32'hFFFF1);
        tick();
        run_op(10'h200, 10'h200, 0, dc, bc, c1, c2, c3);
        check_vec("t6_m512sq", 32'(product_o), 32'h40000);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
